ysyx_23060208_arbiter: RTL and testbench

AXI4 two-master / one-slave arbiter sitting directly downstream of the fetch unit (IFU) and the execute unit's data-memory port (EXU `dsram_*`). It serializes their requests onto the single core memory master port `io_master_*`, which goes to the SoC/SRAM. Only one transaction is outstanding at a time. Masters are selected round-robin and each transaction is held until its final response beat.

---
 rtl/ysyx_23060208_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ysyx_23060208_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter.
// One transaction in flight; round-robin between IFU and LSU; combinational forwarding.
module ysyx_23060208_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  // IFU read
  input  logic                    ifu_arvalid,
  input  logic [3:0]              ifu_arid,
  input  logic [7:0]              ifu_arlen,
  input  logic [2:0]              ifu_arsize,
  input  logic [1:0]              ifu_arburst,
  input  logic [ADDR_WIDTH-1:0]   ifu_araddr,
  output logic                    ifu_arready,
  output logic                    ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic [1:0]              ifu_rresp,
  output logic                    ifu_rlast,
  output logic [3:0]              ifu_rid,
  input  logic                    ifu_rready,
  // LSU read
  input  logic                    lsu_arvalid,
  input  logic [3:0]              lsu_arid,
  input  logic [7:0]              lsu_arlen,
  input  logic [2:0]              lsu_arsize,
  input  logic [1:0]              lsu_arburst,
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
  output logic                    lsu_arready,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic [1:0]              lsu_rresp,
  output logic                    lsu_rlast,
  output logic [3:0]              lsu_rid,
  input  logic                    lsu_rready,
  // LSU write
  input  logic                    lsu_awvalid,
  input  logic [3:0]              lsu_awid,
  input  logic [7:0]              lsu_awlen,
  input  logic [2:0]              lsu_awsize,
  input  logic [1:0]              lsu_awburst,
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
  output logic                    lsu_awready,
  input  logic                    lsu_wvalid,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  input  logic                    lsu_wlast,
  output logic                    lsu_wready,
  output logic                    lsu_bvalid,
  output logic [1:0]              lsu_bresp,
  output logic [3:0]              lsu_bid,
  input  logic                    lsu_bready,
  // slave side
  output logic                    io_master_arvalid,
  output logic [3:0]              io_master_arid,
  output logic [7:0]              io_master_arlen,
  output logic [2:0]              io_master_arsize,
  output logic [1:0]              io_master_arburst,
  output logic [ADDR_WIDTH-1:0]   io_master_araddr,
  input  logic                    io_master_arready,
  input  logic                    io_master_rvalid,
  input  logic [DATA_WIDTH-1:0]   io_master_rdata,
  input  logic [1:0]              io_master_rresp,
  input  logic                    io_master_rlast,
  input  logic [3:0]              io_master_rid,
  output logic                    io_master_rready,
  output logic                    io_master_awvalid,
  output logic [3:0]              io_master_awid,
  output logic [7:0]              io_master_awlen,
  output logic [2:0]              io_master_awsize,
  output logic [1:0]              io_master_awburst,
  output logic [ADDR_WIDTH-1:0]   io_master_awaddr,
  input  logic                    io_master_awready,
  output logic                    io_master_wvalid,
  output logic [DATA_WIDTH-1:0]   io_master_wdata,
  output logic [DATA_WIDTH/8-1:0] io_master_wstrb,
  output logic                    io_master_wlast,
  input  logic                    io_master_wready,
  input  logic                    io_master_bvalid,
  input  logic [1:0]              io_master_bresp,
  input  logic [3:0]              io_master_bid,
  output logic                    io_master_bready,
  output logic [1:0]              grant
);

  // State encoding doubles as the grant code.
  typedef enum logic [1:0] {IDLE = 2'b00, IFU_RD = 2'b01, LSU_RD = 2'b10, LSU_WR = 2'b11} state_t;

  state_t state, state_n;
  logic   last, a_done, w_done;
  logic   rd_done, wr_done;

  assign grant   = state;
  assign rd_done = io_master_rvalid & io_master_rready & io_master_rlast;
  assign wr_done = io_master_bvalid & io_master_bready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      a_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) last <= (state_n != IFU_RD);
      if (state_n == IDLE) begin
        a_done <= 1'b0;
        w_done <= 1'b0;
      end else begin
        if ((io_master_arvalid && io_master_arready) || (io_master_awvalid && io_master_awready))
          a_done <= 1'b1;
        if (io_master_wvalid && io_master_wready && io_master_wlast) w_done <= 1'b1;
      end
    end
  end

  // IFU wins unless the LSU is also asking and the IFU was served last.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ifu_arvalid && (!(lsu_arvalid || lsu_awvalid) || last)) state_n = IFU_RD;
        else if (lsu_arvalid)                                      state_n = LSU_RD;
        else if (lsu_awvalid)                                      state_n = LSU_WR;
      end
      IFU_RD, LSU_RD: if (rd_done) state_n = IDLE;
      LSU_WR:         if (wr_done) state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_comb begin
    ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0; ifu_rresp = '0; ifu_rlast = 1'b0; ifu_rid = '0;
    lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0; lsu_rresp = '0; lsu_rlast = 1'b0; lsu_rid = '0;
    lsu_awready = 1'b0; lsu_wready = 1'b0; lsu_bvalid = 1'b0; lsu_bresp = '0; lsu_bid = '0;
    io_master_arvalid = 1'b0; io_master_arid = '0; io_master_arlen = '0;
    io_master_arsize = '0; io_master_arburst = '0; io_master_araddr = '0;
    io_master_rready = 1'b0;
    io_master_awvalid = 1'b0; io_master_awid = '0; io_master_awlen = '0;
    io_master_awsize = '0; io_master_awburst = '0; io_master_awaddr = '0;
    io_master_wvalid = 1'b0; io_master_wdata = '0; io_master_wstrb = '0; io_master_wlast = 1'b0;
    io_master_bready = 1'b0;
    case (state)
      IFU_RD: begin
        io_master_arvalid = ifu_arvalid & ~a_done;
        io_master_arid    = ifu_arid;
        io_master_arlen   = ifu_arlen;
        io_master_arsize  = ifu_arsize;
        io_master_arburst = ifu_arburst;
        io_master_araddr  = ifu_araddr;
        ifu_arready       = io_master_arready & ~a_done;
        ifu_rvalid        = io_master_rvalid;
        ifu_rdata         = io_master_rdata;
        ifu_rresp         = io_master_rresp;
        ifu_rlast         = io_master_rlast;
        ifu_rid           = io_master_rid;
        io_master_rready  = ifu_rready;
      end
      LSU_RD: begin
        io_master_arvalid = lsu_arvalid & ~a_done;
        io_master_arid    = lsu_arid;
        io_master_arlen   = lsu_arlen;
        io_master_arsize  = lsu_arsize;
        io_master_arburst = lsu_arburst;
        io_master_araddr  = lsu_araddr;
        lsu_arready       = io_master_arready & ~a_done;
        lsu_rvalid        = io_master_rvalid;
        lsu_rdata         = io_master_rdata;
        lsu_rresp         = io_master_rresp;
        lsu_rlast         = io_master_rlast;
        lsu_rid           = io_master_rid;
        io_master_rready  = lsu_rready;
      end
      LSU_WR: begin
        io_master_awvalid = lsu_awvalid & ~a_done;
        io_master_awid    = lsu_awid;
        io_master_awlen   = lsu_awlen;
        io_master_awsize  = lsu_awsize;
        io_master_awburst = lsu_awburst;
        io_master_awaddr  = lsu_awaddr;
        lsu_awready       = io_master_awready & ~a_done;
        // W may lead AW; it stops once the last beat has gone through.
        io_master_wvalid  = lsu_wvalid & ~w_done;
        io_master_wdata   = lsu_wdata;
        io_master_wstrb   = lsu_wstrb;
        io_master_wlast   = lsu_wlast;
        lsu_wready        = io_master_wready & ~w_done;
        lsu_bvalid        = io_master_bvalid;
        lsu_bresp         = io_master_bresp;
        lsu_bid           = io_master_bid;
        io_master_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_arbiter.sv
// Bench for ysyx_23060208_arbiter: bench-side masters and slave, a transaction-level
// ownership model checked every cycle, directed scenarios and a random soak.
module tb_ysyx_23060208_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clock = 1'b0, reset;
  always #5 clock = ~clock;

  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [3:0] ifu_arid, ifu_rid; logic [7:0] ifu_arlen; logic [2:0] ifu_arsize;
  logic [1:0] ifu_arburst, ifu_rresp; logic [AW-1:0] ifu_araddr; logic [DW-1:0] ifu_rdata;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [3:0] lsu_arid, lsu_rid; logic [7:0] lsu_arlen; logic [2:0] lsu_arsize;
  logic [1:0] lsu_arburst, lsu_rresp; logic [AW-1:0] lsu_araddr; logic [DW-1:0] lsu_rdata;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready, lsu_bvalid, lsu_bready;
  logic [3:0] lsu_awid, lsu_bid; logic [7:0] lsu_awlen; logic [2:0] lsu_awsize;
  logic [1:0] lsu_awburst, lsu_bresp; logic [AW-1:0] lsu_awaddr;
  logic [DW-1:0] lsu_wdata; logic [DW/8-1:0] lsu_wstrb;
  logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rlast, io_master_rready;
  logic [3:0] io_master_arid, io_master_rid; logic [7:0] io_master_arlen; logic [2:0] io_master_arsize;
  logic [1:0] io_master_arburst, io_master_rresp; logic [AW-1:0] io_master_araddr;
  logic [DW-1:0] io_master_rdata;
  logic io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wlast, io_master_wready;
  logic io_master_bvalid, io_master_bready;
  logic [3:0] io_master_awid, io_master_bid; logic [7:0] io_master_awlen; logic [2:0] io_master_awsize;
  logic [1:0] io_master_awburst, io_master_bresp; logic [AW-1:0] io_master_awaddr;
  logic [DW-1:0] io_master_wdata; logic [DW/8-1:0] io_master_wstrb;
  logic [1:0] grant;

  ysyx_23060208_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
    .ifu_arburst(ifu_arburst), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
    .lsu_arburst(lsu_arburst), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
    .lsu_awburst(lsu_awburst), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
    .lsu_bready(lsu_bready),
    .io_master_arvalid(io_master_arvalid), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_araddr(io_master_araddr),
    .io_master_arready(io_master_arready), .io_master_rvalid(io_master_rvalid),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid), .io_master_rready(io_master_rready),
    .io_master_awvalid(io_master_awvalid), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst), .io_master_awaddr(io_master_awaddr),
    .io_master_awready(io_master_awready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast), .io_master_wready(io_master_wready),
    .io_master_bvalid(io_master_bvalid), .io_master_bresp(io_master_bresp),
    .io_master_bid(io_master_bid), .io_master_bready(io_master_bready), .grant(grant)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rdat(input logic [31:0] a, input int b);
    if (a == 32'h8000_0000 && b == 0) return 64'h0000_0013_0000_0297;
    return {a ^ 32'h1357_9bdf, a + 32'(b)};
  endfunction

  // bench configuration
  bit cfg_rand; int cfg_ar_dly, cfg_aw_dly, cfg_b_dly, cfg_gap_beat; bit cfg_wblock;
  // IFU master
  bit i_pend, i_arsent; logic [31:0] i_addr; int i_len, i_beat; logic [3:0] i_id;
  // LSU read master
  bit r_pend, r_arsent; logic [31:0] r_addr; int r_len, r_beat, r_rx; logic [3:0] r_id;
  // LSU write master
  bit w_pend, w_awsent, w_vld; logic [31:0] w_addr; int w_len, w_sent;
  logic [3:0] w_id; logic [63:0] w_base; logic [7:0] w_strb; logic [1:0] w_last_bresp;
  // slave
  bit s_rd_act, s_rvld, s_aw_got, s_wlast_got, s_bvld;
  logic [31:0] s_addr; int s_len, s_beat, s_arcnt, s_awcnt, s_wbeat, s_bcnt, aw_hs_cnt;
  logic [3:0] s_id, s_bid; logic [1:0] s_rresp, s_bresp; logic [63:0] s_last_wdata;
  // ownership model: 0 idle, 1 IFU read, 2 LSU read, 3 LSU write
  int m_own; bit m_last, m_adone, m_wdone;
  int gq[$];

  task automatic m_reset();
    m_own = 0; m_last = 1'b1; m_adone = 1'b0; m_wdone = 1'b0;
  endtask

  task automatic bench_clear();
    i_pend = 0; i_arsent = 0; r_pend = 0; r_arsent = 0; w_pend = 0; w_awsent = 0; w_vld = 0;
    s_rd_act = 0; s_rvld = 0; s_aw_got = 0; s_wlast_got = 0; s_bvld = 0;
    s_arcnt = 0; s_awcnt = 0; s_wbeat = 0; s_bcnt = 0; s_beat = 0; s_len = 0;
    s_addr = '0; s_id = '0; s_bid = '0; s_rresp = '0; s_bresp = '0;
    i_addr = '0; r_addr = '0; w_addr = '0; i_len = 0; r_len = 0; w_len = 0;
    i_id = '0; r_id = '0; w_id = '0; w_base = '0; w_strb = '0; w_sent = 0;
  endtask

  task automatic i_start(input logic [31:0] a, input int len);
    i_pend = 1; i_arsent = 0; i_addr = a; i_len = len; i_beat = 0; i_id = 4'($urandom);
  endtask
  task automatic r_start(input logic [31:0] a, input int len);
    r_pend = 1; r_arsent = 0; r_addr = a; r_len = len; r_beat = 0; r_rx = 0; r_id = 4'($urandom);
  endtask
  task automatic w_start(input logic [31:0] a, input int len, input logic [63:0] base, input logic [7:0] strb);
    w_pend = 1; w_awsent = 0; w_addr = a; w_len = len; w_sent = 0; w_base = base; w_strb = strb;
    w_id = 4'($urandom); w_vld = cfg_rand ? 1'($urandom) : 1'b1;
  endtask

  function automatic bit rnd(input int pct);
    return cfg_rand ? (($urandom % 100) < pct) : 1'b1;
  endfunction

  task automatic drive();
    ifu_arvalid = i_pend && !i_arsent; ifu_araddr = i_addr; ifu_arlen = 8'(i_len); ifu_arid = i_id;
    ifu_arsize = 3'd3; ifu_arburst = 2'd1; ifu_rready = rnd(70);
    lsu_arvalid = r_pend && !r_arsent; lsu_araddr = r_addr; lsu_arlen = 8'(r_len); lsu_arid = r_id;
    lsu_arsize = 3'd3; lsu_arburst = 2'd1; lsu_rready = rnd(70);
    lsu_awvalid = w_pend && !w_awsent; lsu_awaddr = w_addr; lsu_awlen = 8'(w_len); lsu_awid = w_id;
    lsu_awsize = 3'd3; lsu_awburst = 2'd1;
    lsu_wvalid = w_vld; lsu_wdata = w_base + 64'(w_sent); lsu_wstrb = w_strb; lsu_wlast = (w_sent == w_len);
    lsu_bready = rnd(70);
    io_master_arready = !s_rd_act && !s_aw_got && s_arcnt >= cfg_ar_dly;
    io_master_awready = !s_rd_act && !s_aw_got && s_awcnt >= cfg_aw_dly;
    io_master_rvalid = s_rvld; io_master_rdata = rdat(s_addr, s_beat); io_master_rlast = (s_beat == s_len);
    io_master_rid = s_id; io_master_rresp = s_rresp;
    io_master_wready = !cfg_wblock && !s_wlast_got && rnd(60);
    io_master_bvalid = s_bvld; io_master_bresp = s_bresp; io_master_bid = s_bid;
  endtask

  task automatic sample();
    logic exp_arv, exp_awv, exp_wv, exp_rrdy, exp_brdy, fin;
    if (!reset) m_reset();
    exp_arv  = ((m_own == 1 && ifu_arvalid) || (m_own == 2 && lsu_arvalid)) && !m_adone;
    exp_awv  = m_own == 3 && lsu_awvalid && !m_adone;
    exp_wv   = m_own == 3 && lsu_wvalid && !m_wdone;
    exp_rrdy = (m_own == 1) ? ifu_rready : (m_own == 2) ? lsu_rready : 1'b0;
    exp_brdy = m_own == 3 && lsu_bready;
    chk("grant", grant, 64'(m_own));
    chk("m_arvalid", io_master_arvalid, exp_arv);
    if (exp_arv) chk("m_araddr", io_master_araddr, (m_own == 1) ? i_addr : r_addr);
    chk("m_awvalid", io_master_awvalid, exp_awv);
    chk("m_wvalid", io_master_wvalid, exp_wv);
    chk("m_rready", io_master_rready, exp_rrdy);
    chk("m_bready", io_master_bready, exp_brdy);
    chk("ifu_arready", ifu_arready, m_own == 1 && !m_adone && io_master_arready);
    chk("lsu_arready", lsu_arready, m_own == 2 && !m_adone && io_master_arready);
    chk("lsu_awready", lsu_awready, m_own == 3 && !m_adone && io_master_awready);
    chk("lsu_wready", lsu_wready, m_own == 3 && !m_wdone && io_master_wready);
    chk("ifu_rvalid", ifu_rvalid, m_own == 1 && io_master_rvalid);
    chk("lsu_rvalid", lsu_rvalid, m_own == 2 && io_master_rvalid);
    chk("lsu_bvalid", lsu_bvalid, m_own == 3 && io_master_bvalid);
    if (!reset) return;
    // model advance
    if (m_own == 0) begin
      if (ifu_arvalid && (!(lsu_arvalid || lsu_awvalid) || m_last)) begin
        m_own = 1; m_last = 0; gq.push_back(1);
      end else if (lsu_arvalid || lsu_awvalid) begin
        m_own = lsu_arvalid ? 2 : 3; m_last = 1; gq.push_back(m_own);
      end
    end else begin
      fin = (m_own != 3) ? (io_master_rvalid && exp_rrdy && io_master_rlast) : (io_master_bvalid && exp_brdy);
      if (fin) begin
        m_own = 0; m_adone = 0; m_wdone = 0;
      end else begin
        if ((exp_arv && io_master_arready) || (exp_awv && io_master_awready)) m_adone = 1;
        if (exp_wv && io_master_wready && lsu_wlast) m_wdone = 1;
      end
    end
    // masters
    if (ifu_arvalid && ifu_arready) i_arsent = 1;
    if (ifu_rvalid && ifu_rready) begin
      chk("ifu_rdata", ifu_rdata, rdat(i_addr, i_beat));
      chk("ifu_rlast", ifu_rlast, i_beat == i_len);
      chk("ifu_rid", ifu_rid, i_id);
      if (i_beat == i_len) i_pend = 0;
      i_beat++;
    end
    if (lsu_arvalid && lsu_arready) r_arsent = 1;
    if (lsu_rvalid && lsu_rready) begin
      chk("lsu_rdata", lsu_rdata, rdat(r_addr, r_beat));
      chk("lsu_rlast", lsu_rlast, r_beat == r_len);
      chk("lsu_rid", lsu_rid, r_id);
      if (r_beat == r_len) r_pend = 0;
      r_beat++; r_rx++;
    end
    if (lsu_awvalid && lsu_awready) w_awsent = 1;
    if (lsu_wvalid && lsu_wready) begin w_sent++; w_vld = 0; end
    if (w_pend && !w_vld && w_sent <= w_len && rnd(60)) w_vld = 1;
    if (lsu_bvalid && lsu_bready) begin
      chk("lsu_bid", lsu_bid, w_id);
      chk("w_beats", w_sent, w_len + 1);
      w_last_bresp = lsu_bresp; w_pend = 0;
    end
    // slave
    if (io_master_rvalid && io_master_rready) begin
      if (io_master_rlast) begin s_rd_act = 0; s_rvld = 0; end
      else begin s_beat++; s_rvld = cfg_rand ? rnd(65) : (s_beat != cfg_gap_beat); end
    end else if (s_rd_act && !s_rvld) s_rvld = 1;
    if (io_master_arvalid && io_master_arready) begin
      s_rd_act = 1; s_addr = io_master_araddr; s_len = int'(io_master_arlen); s_id = io_master_arid;
      s_beat = 0; s_arcnt = 0; s_rresp = cfg_rand ? 2'($urandom) : 2'd0;
      s_rvld = cfg_rand ? rnd(65) : (cfg_gap_beat != 0);
      if (cfg_rand) cfg_ar_dly = $urandom % 3;
    end else if (io_master_arvalid) s_arcnt++;
    if (io_master_awvalid && io_master_awready) begin
      chk("s_awaddr", io_master_awaddr, w_addr);
      chk("s_awlen", io_master_awlen, 64'(w_len));
      s_aw_got = 1; s_bid = io_master_awid; s_awcnt = 0; aw_hs_cnt++;
      if (cfg_rand) cfg_aw_dly = $urandom % 4;
    end else if (io_master_awvalid) s_awcnt++;
    if (io_master_wvalid && io_master_wready) begin
      chk("s_wdata", io_master_wdata, w_base + 64'(s_wbeat));
      chk("s_wstrb", io_master_wstrb, w_strb);
      chk("s_wlast", io_master_wlast, s_wbeat == w_len);
      s_last_wdata = io_master_wdata;
      if (io_master_wlast) s_wlast_got = 1;
      s_wbeat++;
    end
    if (io_master_bvalid && io_master_bready) begin
      s_bvld = 0; s_aw_got = 0; s_wlast_got = 0; s_wbeat = 0; s_bcnt = 0;
    end else if (s_aw_got && s_wlast_got && !s_bvld) begin
      if (s_bcnt >= cfg_b_dly) begin s_bvld = 1; s_bresp = cfg_rand ? 2'($urandom) : 2'd0; end
      else s_bcnt++;
    end
  endtask

  task automatic step();
    @(posedge clock); #1; drive(); #7; sample();
  endtask

  task automatic run_idle(input string nm, input int maxc);
    int n = 0;
    while ((i_pend || r_pend || w_pend || m_own != 0) && n < maxc) begin step(); n++; end
    chk({nm, "_timeout"}, 64'(n >= maxc), 64'd0);
    step();
  endtask

  task automatic chk_seq(input string nm, input int n, input int a, input int b, input int c);
    chk({nm, "_n"}, gq.size(), n);
    if (gq.size() >= 1) chk({nm, "_0"}, gq[0], a);
    if (gq.size() >= 2) chk({nm, "_1"}, gq[1], b);
    if (n == 3 && gq.size() >= 3) chk({nm, "_2"}, gq[2], c);
    gq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; bench_clear(); m_reset(); gq.delete();
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    cfg_rand = 0; cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_b_dly = 0; cfg_gap_beat = -1; cfg_wblock = 0;
    aw_hs_cnt = 0; w_last_bresp = '0; s_last_wdata = '0; r_rx = 0; i_beat = 0; r_beat = 0;
    reset = 1'b0; bench_clear(); m_reset(); drive();
    repeat (2) step();
    chk("rst_grant", grant, 0);
    chk("rst_valids", {io_master_arvalid, io_master_awvalid, io_master_wvalid, ifu_rvalid, lsu_rvalid, lsu_bvalid}, 0);
    chk("rst_readies", {ifu_arready, lsu_arready, lsu_awready, lsu_wready, io_master_rready, io_master_bready}, 0);
    reset = 1'b1;
    step();

    // single IFU read
    i_start(32'h8000_0000, 0);
    step(); chk("t1_idle", grant, 2'b00);
    step(); chk("t1_grant", grant, 2'b01); chk("t1_araddr", io_master_araddr, 64'h8000_0000);
    step(); chk("t1_rvalid", ifu_rvalid, 1); chk("t1_rdata", ifu_rdata, 64'h0000_0013_0000_0297);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    step(); chk("t1_back_idle", grant, 2'b00);
    run_idle("t1", 20); gq.delete();

    // contention after reset: IFU first, then round-robin
    do_reset();
    i_start(32'h8000_0100, 1); r_start(32'h8000_0200, 0);
    while (i_pend) step();
    i_start(32'h8000_0300, 0);
    run_idle("t2", 60);
    chk_seq("t2_order", 3, 1, 2, 1);

    // LSU write with slow AW and B; IFU waits behind it
    cfg_aw_dly = 3; cfg_b_dly = 2; aw_hs_cnt = 0;
    w_start(32'ha000_03f8, 0, 64'h41, 8'h01);
    step(); step(); chk("t3_grant", grant, 2'b11);
    i_start(32'h8000_0400, 0);
    run_idle("t3", 60);
    chk("t3_aw_once", aw_hs_cnt, 1);
    chk("t3_bresp", w_last_bresp, 0);
    chk("t3_wdata", s_last_wdata, 64'h41);
    chk_seq("t3_order", 2, 3, 1, 0);
    cfg_aw_dly = 0; cfg_b_dly = 0;

    // LSU burst read with a mid-burst bubble
    cfg_gap_beat = 2;
    r_start(32'h8000_1000, 3);
    run_idle("t4", 60);
    chk("t4_beats", r_rx, 4);
    chk_seq("t4_order", 1, 2, 0, 0);
    cfg_gap_beat = -1;

    // LSU read and write together: read first
    r_start(32'h8000_2000, 1); w_start(32'ha000_0010, 1, 64'h1000, 8'hff);
    run_idle("t5", 60);
    chk_seq("t5_order", 2, 2, 3, 0);

    // async reset mid-write with W pending
    cfg_aw_dly = 5; cfg_wblock = 1;
    w_start(32'ha000_0020, 0, 64'h77, 8'h0f);
    step(); step(); step(); chk("t6_in_wr", grant, 2'b11);
    @(posedge clock); #3; reset = 1'b0; #1;
    chk("t6_grant", grant, 0);
    chk("t6_m_valids", {io_master_arvalid, io_master_awvalid, io_master_wvalid, io_master_bready}, 0);
    chk("t6_lsu", {lsu_awready, lsu_wready, lsu_bvalid, lsu_rvalid, ifu_rvalid}, 0);
    cfg_aw_dly = 0; cfg_wblock = 0;
    bench_clear(); m_reset(); gq.delete();
    step(); step(); reset = 1'b1;
    i_start(32'h8000_0000, 0);
    run_idle("t6", 30);
    chk_seq("t6_order", 1, 1, 0, 0);

    // random soak
    cfg_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && $urandom % 3 == 0) i_start({$urandom} & 32'hffff_fff8, $urandom % 4);
      if (!r_pend && !w_pend && $urandom % 3 == 0) begin
        case ($urandom % 3)
          0: r_start({$urandom} & 32'hffff_fff8, $urandom % 4);
          1: w_start({$urandom} & 32'hffff_fff8, $urandom % 4, {$urandom, $urandom}, 8'($urandom));
          default: begin
            r_start({$urandom} & 32'hffff_fff8, $urandom % 4);
            w_start({$urandom} & 32'hffff_fff8, $urandom % 4, {$urandom, $urandom}, 8'($urandom));
          end
        endcase
      end
      step();
    end
    run_idle("rand", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
